// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST controller owning a single-port RAM port, muxing functional traffic while idle.
// Optional MBIST_FAIL_LOG_EN: log first mismatch and count mismatches instead of aborting on the first one.
module mbist_march_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] BG_PATTERN = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  input  logic              func_we,
  input  logic [ADDR_W-1:0] func_addr,
  input  logic [DATA_W-1:0] func_din,
  output logic              func_rdy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef MBIST_FAIL_LOG_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [7:0]        fail_cnt
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  localparam logic [ADDR_W-1:0] MAX = '1;
  logic [1:0] state;
  logic [2:0] elem;
  logic [ADDR_W-1:0] addr;
  logic phase, rd_pend;
  logic [DATA_W-1:0] exp_q;
  logic two_op, down, op_we, step, elem_end, last_op, mismatch, abort;
  logic [DATA_W-1:0] op_din, rd_val;
  logic [ADDR_W-1:0] nxt_addr;
  // e1..e4 are read-then-write per address; e0 is write-only, e5 read-only
  assign two_op   = (elem != 3'd0) && (elem != 3'd5);
  assign down     = (elem == 3'd3) || (elem == 3'd4);
  assign op_we    = two_op ? phase : (elem == 3'd0);
  assign op_din   = elem[0] ? ~BG_PATTERN : BG_PATTERN;
  assign rd_val   = elem[0] ? BG_PATTERN : ~BG_PATTERN;
  assign step     = !two_op || phase;
  assign elem_end = step && (down ? (addr == '0) : (addr == MAX));
  assign last_op  = (elem == 3'd5) && elem_end;
  assign nxt_addr = ((elem == 3'd2) || (elem == 3'd3)) ? MAX : '0;
  assign mismatch = rd_pend && (state != IDLE) && (ram_dout != exp_q);
  assign busy     = state != IDLE;
  assign func_rdy = !busy;
  assign ram_we   = busy ? ((state == RUN) && op_we) : func_we;
  assign ram_addr = busy ? addr : func_addr;
  assign ram_din  = busy ? op_din : func_din;
`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] cmp_addr;
  logic [2:0] cmp_elem;
  assign abort = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmp_addr  <= '0;
      cmp_elem  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      fail_cnt  <= '0;
    end else begin
      cmp_addr <= addr;
      cmp_elem <= elem;
      if (state == IDLE && start) begin
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
        fail_cnt  <= '0;
      end else if (mismatch) begin
        if (!fail) begin
          fail_addr <= cmp_addr;
          fail_elem <= cmp_elem;
          fail_data <= ram_dout ^ exp_q;
        end
        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
      end
    end
`else
  assign abort = mismatch;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      elem    <= '0;
      addr    <= '0;
      phase   <= 1'b0;
      rd_pend <= 1'b0;
      exp_q   <= '0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      rd_pend <= (state == RUN) && !op_we;
      exp_q   <= rd_val;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          elem  <= '0;
          addr  <= '0;
          phase <= 1'b0;
          done  <= 1'b0;
          fail  <= 1'b0;
        end
      end else begin
        if (mismatch) fail <= 1'b1;
        if (state == DRAIN || abort) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          phase <= two_op && !phase;
          if (last_op) state <= DRAIN;
          else if (elem_end) begin
            elem <= elem + 3'd1;
            addr <= nxt_addr;
          end else if (step) addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: two controllers (backgrounds 0x00 and 0x55) against a March C- op-list model with RAM models and read-fault injection.
module tb_mbist_march_ctrl;
  logic clk = 1'b0, rst_n, start, func_we, fault;
  logic [5:0] func_addr;
  logic [7:0] func_din;
  logic busy [2], done [2], fail [2], func_rdy [2], ram_we [2];
  logic [5:0] ram_addr [2];
  logic [7:0] ram_din [2], ram_dout [2];
  int pass_cnt = 0, total = 0;
  int exp_len [2], idx [2];
  bit exp_fail [2], pb [2], m_done [2], m_fail [2];
  bit m_we [2][640];
  logic [5:0] m_addr [2][640];
  logic [7:0] m_dat [2][640];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : ch
    logic [7:0] mem [64];
    logic [7:0] rq;
    logic [5:0] aq;
    mbist_march_ctrl #(.BG_PATTERN(g == 1 ? 8'h55 : 8'h00)) u (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[g]), .done(done[g]), .fail(fail[g]),
      .func_we(func_we), .func_addr(func_addr), .func_din(func_din), .func_rdy(func_rdy[g]),
      .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_din(ram_din[g]), .ram_dout(ram_dout[g]));
    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
      rq <= mem[ram_addr[g]];
      aq <= ram_addr[g];
    end
    assign ram_dout[g] = rq | ((fault && aq == 6'd5) ? 8'h08 : 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    else pass_cnt++;
  endtask

  // op list straight from the element table: (dir, ops) per element
  task automatic build();
    for (int c = 0; c < 2; c++) begin
      logic [7:0] bg;
      int n;
      bg = (c == 1) ? 8'h55 : 8'h00;
      n = 0;
      for (int e = 0; e < 6; e++)
        for (int j = 0; j < 64; j++) begin
          int a;
          bit v;
          a = (e == 3 || e == 4) ? 63 - j : j;
          v = (e == 2 || e == 4);
          if (e == 0 || e == 5) begin
            m_we[c][n] = (e == 0); m_addr[c][n] = 6'(a); m_dat[c][n] = bg; n++;
          end else begin
            m_we[c][n] = 0; m_addr[c][n] = 6'(a); m_dat[c][n] = v ? ~bg : bg; n++;
            m_we[c][n] = 1; m_addr[c][n] = 6'(a); m_dat[c][n] = v ? bg : ~bg; n++;
          end
        end
    end
  endtask

  function automatic int first_bad(int c, bit f);
    for (int i = 0; i < 640; i++)
      if (!m_we[c][i] && f && m_addr[c][i] == 6'd5 && (m_dat[c][i] | 8'h08) != m_dat[c][i]) return i;
    return -1;
  endfunction

  always @(negedge clk)
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        idx[c] = 0; pb[c] = 0; m_done[c] = 0; m_fail[c] = 0;
      end else if (busy[c]) begin
        chk("busy_done", done[c], 0);
        chk("busy_fail", fail[c], 0);
        chk("busy_rdy", func_rdy[c], 0);
        if (idx[c] < 640) begin
          chk("op_we", ram_we[c], m_we[c][idx[c]]);
          chk("op_addr", ram_addr[c], m_addr[c][idx[c]]);
          if (m_we[c][idx[c]]) chk("op_din", ram_din[c], m_dat[c][idx[c]]);
        end else chk("drain_we", ram_we[c], 0);
        idx[c]++; pb[c] = 1;
      end else begin
        if (pb[c]) begin
          chk("busy_len", idx[c], exp_len[c]);
          m_done[c] = 1; m_fail[c] = exp_fail[c]; idx[c] = 0; pb[c] = 0;
        end
        chk("idle_done", done[c], m_done[c]);
        chk("idle_fail", fail[c], m_fail[c]);
        chk("idle_rdy", func_rdy[c], 1);
        chk("idle_we", ram_we[c], func_we);
        chk("idle_addr", ram_addr[c], func_addr);
        chk("idle_din", ram_din[c], func_din);
      end
    end

  task automatic cyc();
    @(posedge clk);
    #1;
    func_we = 1'($urandom);
    func_addr = 6'($urandom);
    func_din = 8'($urandom);
  endtask

  task automatic launch(input bit f);
    fault = f;
    for (int c = 0; c < 2; c++) begin
      int k;
      k = first_bad(c, f);
      exp_len[c] = (k < 0) ? 641 : k + 2;
      exp_fail[c] = (k >= 0);
    end
    repeat ($urandom_range(1, 6)) cyc();
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic run(input bit f);
    bit fin;
    launch(f);
    fin = 0;
    for (int i = 0; i < 900 && !fin; i++) begin
      cyc();
      if (!busy[0] && !busy[1]) begin start = 0; fin = 1; end
      else start = ($urandom_range(0, 15) == 0);
    end
    if (!fin) chk("run_timeout", 1, 0);
    start = 0;
    repeat (3) cyc();
  endtask

  initial begin
    rst_n = 0; start = 0; fault = 0; func_we = 0; func_addr = 0; func_din = 0;
    build();
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_busy", busy[c], 0);
      chk("rst_done", done[c], 0);
      chk("rst_fail", fail[c], 0);
      chk("rst_rdy", func_rdy[c], 1);
    end
    begin
      int w;
      w = 0;
      for (int i = 0; i < 640; i++) w += m_we[0][i];
      chk("model_writes", w, 320);
    end
    chk("model_bad_bg00", first_bad(0, 1), 74);
    chk("model_bad_bg55", first_bad(1, 1), 74);
    chk("model_clean", first_bad(0, 0), 32'hFFFFFFFF);
    chk("model_e3_a0", m_addr[0][320], 63);
    chk("model_e3_a1", m_addr[0][321], 63);
    chk("model_e3_a2", m_addr[0][322], 62);
    chk("model_e4_last", m_addr[0][575], 0);
    chk("model_bg55_w0", m_dat[1][0], 8'h55);
    chk("model_bg55_w1", m_dat[1][65], 8'hAA);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run(0);
    chk("lit_done_clean", done[0], 1);
    chk("lit_fail_clean", fail[0], 0);
    run(1);
    chk("lit_fail_fault", fail[0], 1);
    chk("lit_fail_fault55", fail[1], 1);
    run(0);
    launch(0);
    repeat (300) cyc();
    func_we = 0;
    #1 rst_n = 0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("mid_rst_busy", busy[c], 0);
      chk("mid_rst_done", done[c], 0);
      chk("mid_rst_fail", fail[c], 0);
      chk("mid_rst_we", ram_we[c], 0);
    end
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    run(0);
    chk("lit_restart_done", done[1], 1);
    for (int r = 0; r < 3; r++) run(1'($urandom));
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
